// File: rtl/pipeline_pkg.sv
// Shared types for the ID/EX pipeline register and its hazard logic:
// control/data bundles, result-source, ALU and forward-select encodings.
package pipeline_pkg;

   typedef enum logic [1:0] {
      RES_ALU  = 2'b00,
      RES_LOAD = 2'b01,
      RES_PC4  = 2'b10
   } result_src_e;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   typedef struct packed {
      logic       RegWrite;
      logic [1:0] ResultSrc;
      logic       MemWrite;
      logic       Jump;
      logic       Branch;
      logic [2:0] ALUControl;
      logic       ALUSrc;
   } ctrl_t;

   typedef struct packed {
      logic [31:0] RD1;
      logic [31:0] RD2;
      logic [31:0] PC;
      logic [31:0] ImmExt;
      logic [31:0] PCPlus4;
      logic [4:0]  Rs1;
      logic [4:0]  Rs2;
      logic [4:0]  Rd;
   } idex_data_t;

   // An all-zero bundle is an inert nop: no register/memory write, no jump or branch, ADD.
   localparam ctrl_t      CTRL_BUBBLE = '0;
   localparam idex_data_t DATA_BUBBLE = '0;

   // x0 is hardwired to zero, so it never participates in a dependency.
   function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
      return (rd != 5'd0) && (rd == rs);
   endfunction

   function automatic logic [1:0] forward_sel(input logic       valid,
                                              input logic [4:0] rs,
                                              input logic [4:0] rd_m,
                                              input logic       we_m,
                                              input logic [4:0] rd_w,
                                              input logic       we_w);
      logic [1:0] sel;
      sel = FWD_RF;
      if (valid) begin
         if (we_m && reg_match(rd_m, rs))
            sel = FWD_MEM;
         else if (we_w && reg_match(rd_w, rs))
            sel = FWD_WB;
      end
      return sel;
   endfunction

endpackage

// File: rtl/id_ex_pipeline_if.sv
// Decode-side inputs, execute-side register outputs and hazard controls of the ID/EX stage.
interface id_ex_pipeline_if;
   import pipeline_pkg::*;

   ctrl_t      ctrlD;
   idex_data_t dataD;
   logic       PCSrcE;
   logic [4:0] RdM;
   logic [4:0] RdW;
   logic       RegWriteM;
   logic       RegWriteW;

   ctrl_t      ctrlE;
   idex_data_t dataE;
   logic       ValidE;
   logic       StallF;
   logic       StallD;
   logic       FlushD;
   logic [1:0] ForwardAE;
   logic [1:0] ForwardBE;

   modport master (
      output ctrlD, dataD, PCSrcE, RdM, RdW, RegWriteM, RegWriteW,
      input  ctrlE, dataE, ValidE, StallF, StallD, FlushD, ForwardAE, ForwardBE
   );

   modport slave (
      input  ctrlD, dataD, PCSrcE, RdM, RdW, RegWriteM, RegWriteW,
      output ctrlE, dataE, ValidE, StallF, StallD, FlushD, ForwardAE, ForwardBE
   );

endinterface

// File: rtl/hazard_unit.sv
// Combinational load-use stall, redirect flush and operand forwarding selects
// for an instruction sitting in execute.
module hazard_unit
   import pipeline_pkg::*;
(
   input  logic [1:0] result_src_e,
   input  logic       valid_e,
   input  logic [4:0] rd_e,
   input  logic [4:0] rs1_e,
   input  logic [4:0] rs2_e,
   input  logic [4:0] rs1_d,
   input  logic [4:0] rs2_d,
   input  logic       pcsrc_e,
   input  logic [4:0] rd_m,
   input  logic [4:0] rd_w,
   input  logic       reg_write_m,
   input  logic       reg_write_w,
   output logic       stall_f,
   output logic       stall_d,
   output logic       flush_d,
   output logic       bubble,
   output logic [1:0] forward_ae,
   output logic [1:0] forward_be
);

   logic lw_stall;

   always_comb begin
      // A taken redirect discards the dependent instruction, so it overrides the stall.
      lw_stall   = (result_src_e == RES_LOAD) && valid_e && !pcsrc_e &&
                   (reg_match(rd_e, rs1_d) || reg_match(rd_e, rs2_d));
      stall_f    = lw_stall;
      stall_d    = lw_stall;
      flush_d    = pcsrc_e;
      bubble     = lw_stall || pcsrc_e;
      forward_ae = forward_sel(valid_e, rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
      forward_be = forward_sel(valid_e, rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
   end

endmodule

// File: rtl/id_ex_pipeline.sv
// ID/EX pipeline register with bubble insertion; hazard detection and
// forwarding are delegated to hazard_unit.
module id_ex_pipeline
   import pipeline_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   id_ex_pipeline_if.slave   bus
);

   ctrl_t      ctrl_q;
   idex_data_t data_q;
   logic       valid_q;
   logic       bubble;

   hazard_unit u_hazard (
      .result_src_e (ctrl_q.ResultSrc),
      .valid_e      (valid_q),
      .rd_e         (data_q.Rd),
      .rs1_e        (data_q.Rs1),
      .rs2_e        (data_q.Rs2),
      .rs1_d        (bus.dataD.Rs1),
      .rs2_d        (bus.dataD.Rs2),
      .pcsrc_e      (bus.PCSrcE),
      .rd_m         (bus.RdM),
      .rd_w         (bus.RdW),
      .reg_write_m  (bus.RegWriteM),
      .reg_write_w  (bus.RegWriteW),
      .stall_f      (bus.StallF),
      .stall_d      (bus.StallD),
      .flush_d      (bus.FlushD),
      .bubble       (bubble),
      .forward_ae   (bus.ForwardAE),
      .forward_be   (bus.ForwardBE)
   );

   // The bubble clears ValidE, which is what keeps a load-use stall to a single cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q  <= CTRL_BUBBLE;
         data_q  <= DATA_BUBBLE;
         valid_q <= 1'b0;
      end else if (bubble) begin
         ctrl_q  <= CTRL_BUBBLE;
         data_q  <= DATA_BUBBLE;
         valid_q <= 1'b0;
      end else begin
         ctrl_q  <= bus.ctrlD;
         data_q  <= bus.dataD;
         valid_q <= 1'b1;
      end
   end

   assign bus.ctrlE  = ctrl_q;
   assign bus.dataE  = data_q;
   assign bus.ValidE = valid_q;

endmodule

// File: tb/tb_id_ex_pipeline.sv
// Bench for id_ex_pipeline: reference-model driven random run, a hazard
// vector table and hand-written multi-cycle sequences.
module tb_id_ex_pipeline;
   import pipeline_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   id_ex_pipeline_if bus ();

   id_ex_pipeline dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference execute slot: what the ID/EX register should hold.
   ctrl_t      m_ctrl;
   idex_data_t m_data;
   logic       m_valid;

   typedef struct {
      string      name;
      logic [1:0] res_e;
      logic [4:0] rd_e;
      logic [4:0] rs1_e;
      logic [4:0] rs2_e;
      logic [4:0] rs1_d;
      logic [4:0] rs2_d;
      logic       pcsrc;
      logic [4:0] rd_m;
      logic       we_m;
      logic [4:0] rd_w;
      logic       we_w;
      logic       x_stall;
      logic       x_flush;
      logic [1:0] x_fa;
      logic [1:0] x_fb;
   } vec_t;

   vec_t vecs[13];

   function automatic vec_t mk(string n, logic [1:0] res, logic [4:0] rde, logic [4:0] r1e,
                               logic [4:0] r2e, logic [4:0] r1d, logic [4:0] r2d, logic pc,
                               logic [4:0] rdm, logic wem, logic [4:0] rdw, logic wew,
                               logic xs, logic xf, logic [1:0] xa, logic [1:0] xb);
      vec_t v;
      v.name = n; v.res_e = res; v.rd_e = rde; v.rs1_e = r1e; v.rs2_e = r2e;
      v.rs1_d = r1d; v.rs2_d = r2d; v.pcsrc = pc; v.rd_m = rdm; v.we_m = wem;
      v.rd_w = rdw; v.we_w = wew; v.x_stall = xs; v.x_flush = xf; v.x_fa = xa; v.x_fb = xb;
      return v;
   endfunction

   function automatic logic model_load_use();
      if (!m_valid || m_ctrl.ResultSrc != 2'b01 || m_data.Rd == 5'd0 || bus.PCSrcE)
         return 1'b0;
      return (m_data.Rd == bus.dataD.Rs1) || (m_data.Rd == bus.dataD.Rs2);
   endfunction

   function automatic logic [1:0] model_fwd(input logic [4:0] rs);
      if (!m_valid || rs == 5'd0) return 2'b00;
      if (bus.RegWriteM && bus.RdM == rs) return 2'b10;
      if (bus.RegWriteW && bus.RdW == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [4:0] rreg();
      return 5'($urandom_range(0, 7));
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, 256'(act), 256'(exp));
   endtask

   task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
      chk(name, 256'(act), 256'(exp));
   endtask

   task automatic check_comb(input string tag);
      logic lu;
      lu = model_load_use();
      chk1({tag, " StallF"}, bus.StallF, lu);
      chk1({tag, " StallD"}, bus.StallD, lu);
      chk1({tag, " FlushD"}, bus.FlushD, bus.PCSrcE);
      chk2({tag, " ForwardAE"}, bus.ForwardAE, model_fwd(m_data.Rs1));
      chk2({tag, " ForwardBE"}, bus.ForwardBE, model_fwd(m_data.Rs2));
   endtask

   task automatic check_regs(input string tag);
      chk({tag, " ctrlE"}, 256'(bus.ctrlE), 256'(m_ctrl));
      chk({tag, " dataE"}, 256'(bus.dataE), 256'(m_data));
      chk1({tag, " ValidE"}, bus.ValidE, m_valid);
   endtask

   // One rising edge; the model advances from the inputs held across it.
   task automatic clock_edge();
      logic       bub;
      ctrl_t      c;
      idex_data_t d;
      bub = model_load_use() || bus.PCSrcE;
      c   = bus.ctrlD;
      d   = bus.dataD;
      @(posedge clk);
      if (!rst_n || bub) begin
         m_ctrl = '0; m_data = '0; m_valid = 1'b0;
      end else begin
         m_ctrl = c; m_data = d; m_valid = 1'b1;
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      m_ctrl = '0; m_data = '0; m_valid = 1'b0;
      rst_n = 1'b1;
      #1;
   endtask

   task automatic drive_d(input logic [1:0] res, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2);
      bus.ctrlD = 10'($urandom());
      bus.ctrlD.ResultSrc = res;
      bus.dataD = 175'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      bus.dataD.Rd  = rd;
      bus.dataD.Rs1 = rs1;
      bus.dataD.Rs2 = rs2;
   endtask

   task automatic drive_mw(input logic pc, input logic [4:0] rdm, input logic wem,
                           input logic [4:0] rdw, input logic wew);
      bus.PCSrcE = pc; bus.RdM = rdm; bus.RegWriteM = wem; bus.RdW = rdw; bus.RegWriteW = wew;
   endtask

   ctrl_t saved_ctrl;
   idex_data_t saved_data;

   initial begin
      vecs[0]  = mk("lu_rs1",       2'b01, 5'd5, 5'd1, 5'd2, 5'd5, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
      vecs[1]  = mk("lu_rs2",       2'b01, 5'd5, 5'd1, 5'd2, 5'd6, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
      vecs[2]  = mk("lu_nomatch",   2'b01, 5'd5, 5'd1, 5'd2, 5'd6, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      vecs[3]  = mk("lu_x0",        2'b01, 5'd0, 5'd1, 5'd2, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      vecs[4]  = mk("alu_nostall",  2'b00, 5'd5, 5'd1, 5'd2, 5'd5, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      vecs[5]  = mk("pc4_nostall",  2'b10, 5'd5, 5'd1, 5'd2, 5'd5, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      vecs[6]  = mk("redirect_win", 2'b01, 5'd5, 5'd1, 5'd2, 5'd5, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
      vecs[7]  = mk("fwd_mem_prio", 2'b00, 5'd7, 5'd7, 5'd3, 5'd1, 5'd2, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00);
      vecs[8]  = mk("fwd_wb",       2'b00, 5'd7, 5'd7, 5'd3, 5'd1, 5'd2, 1'b0, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00);
      vecs[9]  = mk("fwd_x0",       2'b00, 5'd3, 5'd1, 5'd0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
      vecs[10] = mk("fwd_split",    2'b00, 5'd1, 5'd3, 5'd9, 5'd2, 5'd4, 1'b0, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 2'b10, 2'b01);
      vecs[11] = mk("fwd_both_mem", 2'b00, 5'd1, 5'd4, 5'd4, 5'd2, 5'd3, 1'b0, 5'd4, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10);
      vecs[12] = mk("fwd_we_off",   2'b00, 5'd1, 5'd4, 5'd4, 5'd2, 5'd3, 1'b0, 5'd4, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

      // Reset behaviour with random decode inputs.
      rst_n = 1'b0;
      drive_d(2'b01, 5'd5, 5'd5, 5'd5);
      drive_mw(1'b0, 5'd5, 1'b1, 5'd5, 1'b1);
      m_ctrl = '0; m_data = '0; m_valid = 1'b0;
      #2;
      chk("rst ctrlE", 256'(bus.ctrlE), 256'(0));
      chk("rst dataE", 256'(bus.dataE), 256'(0));
      chk1("rst ValidE", bus.ValidE, 1'b0);
      chk1("rst StallF", bus.StallF, 1'b0);
      chk1("rst FlushD", bus.FlushD, 1'b0);
      chk2("rst ForwardAE", bus.ForwardAE, 2'b00);
      chk2("rst ForwardBE", bus.ForwardBE, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      saved_ctrl = bus.ctrlD;
      clock_edge();
      chk("rel ctrlE", 256'(bus.ctrlE), 256'(saved_ctrl));
      chk1("rel ValidE", bus.ValidE, 1'b1);

      // Hazard vector table.
      for (int i = 0; i < 13; i++) begin
         do_reset();
         drive_mw(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
         drive_d(vecs[i].res_e, vecs[i].rd_e, vecs[i].rs1_e, vecs[i].rs2_e);
         clock_edge();
         check_regs({vecs[i].name, " load"});
         drive_d(2'b00, 5'd1, vecs[i].rs1_d, vecs[i].rs2_d);
         drive_mw(vecs[i].pcsrc, vecs[i].rd_m, vecs[i].we_m, vecs[i].rd_w, vecs[i].we_w);
         #1;
         chk1({vecs[i].name, " StallF"}, bus.StallF, vecs[i].x_stall);
         chk1({vecs[i].name, " StallD"}, bus.StallD, vecs[i].x_stall);
         chk1({vecs[i].name, " FlushD"}, bus.FlushD, vecs[i].x_flush);
         chk2({vecs[i].name, " ForwardAE"}, bus.ForwardAE, vecs[i].x_fa);
         chk2({vecs[i].name, " ForwardBE"}, bus.ForwardBE, vecs[i].x_fb);
         check_comb({vecs[i].name, " model"});
         clock_edge();
         check_regs({vecs[i].name, " next"});
      end

      // Load-use stall lasts exactly one cycle, then the dependent instruction enters.
      do_reset();
      drive_mw(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      drive_d(2'b01, 5'd5, 5'd1, 5'd2);
      clock_edge();
      drive_d(2'b00, 5'd8, 5'd5, 5'd6);
      saved_ctrl = bus.ctrlD;
      saved_data = bus.dataD;
      #1;
      chk1("lu seq StallF", bus.StallF, 1'b1);
      chk1("lu seq StallD", bus.StallD, 1'b1);
      clock_edge();
      chk1("lu seq bubble ValidE", bus.ValidE, 1'b0);
      chk("lu seq bubble ctrlE", 256'(bus.ctrlE), 256'(0));
      chk1("lu seq cleared StallF", bus.StallF, 1'b0);
      clock_edge();
      chk("lu seq ctrlE", 256'(bus.ctrlE), 256'(saved_ctrl));
      chk("lu seq dataE", 256'(bus.dataE), 256'(saved_data));
      chk1("lu seq ValidE", bus.ValidE, 1'b1);

      // Redirect squashes the decode instruction.
      drive_d(2'b00, 5'd9, 5'd1, 5'd2);
      bus.ctrlD.RegWrite = 1'b1;
      bus.PCSrcE = 1'b1;
      #1;
      chk1("redir FlushD", bus.FlushD, 1'b1);
      chk1("redir StallF", bus.StallF, 1'b0);
      clock_edge();
      chk1("redir RegWrite", bus.ctrlE.RegWrite, 1'b0);
      chk1("redir ValidE", bus.ValidE, 1'b0);
      bus.PCSrcE = 1'b0;

      // Reset in the middle of a stall aborts it; next edge loads normally.
      do_reset();
      drive_d(2'b01, 5'd5, 5'd1, 5'd2);
      clock_edge();
      drive_d(2'b00, 5'd3, 5'd5, 5'd5);
      saved_ctrl = bus.ctrlD;
      #1;
      chk1("midrst pre StallF", bus.StallF, 1'b1);
      rst_n = 1'b0;
      #1;
      chk1("midrst StallF", bus.StallF, 1'b0);
      chk1("midrst ValidE", bus.ValidE, 1'b0);
      m_ctrl = '0; m_data = '0; m_valid = 1'b0;
      rst_n = 1'b1;
      clock_edge();
      chk("midrst ctrlE", 256'(bus.ctrlE), 256'(saved_ctrl));
      chk1("midrst ValidE after", bus.ValidE, 1'b1);

      // Randomized run against the reference model.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 99) == 0) do_reset();
         drive_d(2'($urandom_range(0, 3)), rreg(), rreg(), rreg());
         drive_mw(($urandom_range(0, 4) == 0), rreg(), 1'($urandom()), rreg(), 1'($urandom()));
         #1;
         check_comb("rand");
         clock_edge();
         check_regs("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
